// File: rtl/text_tile_renderer_pkg.sv
// Shared constants and types for the text tile renderer: character codes,
// default geometry and the clear/run state encoding.
package text_pkg;

  localparam int DEF_GLYPH_W = 5;
  localparam int DEF_GLYPH_H = 5;
  localparam int DEF_CELL_W  = 8;
  localparam int DEF_CELL_H  = 8;
  localparam int DEF_COLS    = 32;
  localparam int DEF_ROWS    = 30;

  localparam logic [6:0] CHR_SPACE = 7'h20;
  localparam logic [6:0] CHR_EXCL  = 7'h21;
  localparam logic [6:0] CHR_QUOTE = 7'h22;
  localparam logic [6:0] CHR_COMMA = 7'h2C;
  localparam logic [6:0] CHR_0     = 7'h30;
  localparam logic [6:0] CHR_A     = 7'h41;
  localparam logic [6:0] CHR_LC_D  = 7'h64;
  localparam logic [6:0] CHR_LC_E  = 7'h65;
  localparam logic [6:0] CHR_LC_L  = 7'h6C;
  localparam logic [6:0] CHR_LC_O  = 7'h6F;
  localparam logic [6:0] CHR_LC_R  = 7'h72;

  typedef logic [7:0] glyph_row_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/text_tile_renderer_if.sv
// Beam, write-port and pixel signals between the sync generator / host and
// the renderer. Cursor signals exist only with TEXT_CURSOR_BLINK_EN.
interface text_tile_renderer_if #(
  parameter int ADDR_W = 10
) ();
  logic [8:0]        hpos;
  logic [8:0]        vpos;
  logic              display_on;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_char;
  logic              busy;
  logic              pixel;
  logic              pixel_valid;
`ifdef TEXT_CURSOR_BLINK_EN
  logic [ADDR_W-1:0] cursor_addr;
  logic              vsync;

  modport master (
    output hpos, vpos, display_on, wr_en, wr_addr, wr_char, cursor_addr, vsync,
    input  busy, pixel, pixel_valid
  );
  modport slave (
    input  hpos, vpos, display_on, wr_en, wr_addr, wr_char, cursor_addr, vsync,
    output busy, pixel, pixel_valid
  );
`else
  modport master (
    output hpos, vpos, display_on, wr_en, wr_addr, wr_char,
    input  busy, pixel, pixel_valid
  );
  modport slave (
    input  hpos, vpos, display_on, wr_en, wr_addr, wr_char,
    output busy, pixel, pixel_valid
  );
`endif
endinterface

// File: rtl/text_tile_renderer_glyph_rom.sv
// Combinational glyph ROM: 5x5 base shapes, nearest-neighbour scaled to
// GLYPH_W x GLYPH_H. Bit GLYPH_W-1 of bits is the leftmost pixel.
module glyph_rom
  import text_pkg::*;
#(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H
) (
  input  logic [6:0]         code,
  input  logic [2:0]         yofs,
  output logic [GLYPH_W-1:0] bits
);

  // Rows packed top to bottom, each row MSB = leftmost pixel.
  function automatic logic [24:0] base_glyph(input logic [6:0] c);
    case (c)
      CHR_SPACE: base_glyph = 25'b00000_00000_00000_00000_00000;
      CHR_EXCL:  base_glyph = 25'b00100_00100_00100_00000_00100;
      CHR_QUOTE: base_glyph = 25'b01010_01010_00000_00000_00000;
      CHR_COMMA: base_glyph = 25'b00000_00000_00000_00100_01000;
      CHR_0:     base_glyph = 25'b01110_10011_10101_11001_01110;
      7'h31:     base_glyph = 25'b00100_01100_00100_00100_01110;
      7'h32:     base_glyph = 25'b11110_00001_01110_10000_11111;
      7'h33:     base_glyph = 25'b11110_00001_00110_00001_11110;
      7'h34:     base_glyph = 25'b10010_10010_11111_00010_00010;
      7'h35:     base_glyph = 25'b11111_10000_11110_00001_11110;
      7'h36:     base_glyph = 25'b01110_10000_11110_10001_01110;
      7'h37:     base_glyph = 25'b11111_00001_00010_00100_00100;
      7'h38:     base_glyph = 25'b01110_10001_01110_10001_01110;
      7'h39:     base_glyph = 25'b01110_10001_01111_00001_01110;
      CHR_A:     base_glyph = 25'b01110_10001_11111_10001_10001;
      7'h42:     base_glyph = 25'b11110_10001_11110_10001_11110;
      7'h43:     base_glyph = 25'b01111_10000_10000_10000_01111;
      7'h44:     base_glyph = 25'b11110_10001_10001_10001_11110;
      7'h45:     base_glyph = 25'b11111_10000_11110_10000_11111;
      7'h46:     base_glyph = 25'b11111_10000_11110_10000_10000;
      7'h47:     base_glyph = 25'b01111_10000_10011_10001_01111;
      7'h48:     base_glyph = 25'b10001_10001_11111_10001_10001;
      7'h49:     base_glyph = 25'b01110_00100_00100_00100_01110;
      7'h4A:     base_glyph = 25'b00111_00010_00010_10010_01100;
      7'h4B:     base_glyph = 25'b10010_10100_11000_10100_10010;
      7'h4C:     base_glyph = 25'b10000_10000_10000_10000_11111;
      7'h4D:     base_glyph = 25'b10001_11011_10101_10001_10001;
      7'h4E:     base_glyph = 25'b10001_11001_10101_10011_10001;
      7'h4F:     base_glyph = 25'b01110_10001_10001_10001_01110;
      7'h50:     base_glyph = 25'b11110_10001_11110_10000_10000;
      7'h51:     base_glyph = 25'b01110_10001_10101_10010_01101;
      7'h52:     base_glyph = 25'b11110_10001_11110_10010_10001;
      7'h53:     base_glyph = 25'b01111_10000_01110_00001_11110;
      7'h54:     base_glyph = 25'b11111_00100_00100_00100_00100;
      7'h55:     base_glyph = 25'b10001_10001_10001_10001_01110;
      7'h56:     base_glyph = 25'b10001_10001_10001_01010_00100;
      7'h57:     base_glyph = 25'b10001_10001_10101_11011_10001;
      7'h58:     base_glyph = 25'b10001_01010_00100_01010_10001;
      7'h59:     base_glyph = 25'b10001_01010_00100_00100_00100;
      7'h5A:     base_glyph = 25'b11111_00010_00100_01000_11111;
      CHR_LC_D:  base_glyph = 25'b00001_00001_01111_10001_01111;
      CHR_LC_E:  base_glyph = 25'b01110_10001_11111_10000_01110;
      CHR_LC_L:  base_glyph = 25'b01100_00100_00100_00100_01110;
      CHR_LC_O:  base_glyph = 25'b00000_01110_10001_10001_01110;
      CHR_LC_R:  base_glyph = 25'b00000_10110_11000_10000_10000;
      default:   base_glyph = 25'b00000_00000_00000_00000_00000;
    endcase
  endfunction

  logic [24:0] w_glyph;
  logic [3:0]  w_src_row;
  logic [4:0]  w_row5;

  always_comb begin
    w_glyph   = base_glyph(code);
    w_src_row = 4'((32'(yofs) * 32'd5) / 32'(GLYPH_H));
    case (w_src_row)
      4'd0:    w_row5 = w_glyph[24:20];
      4'd1:    w_row5 = w_glyph[19:15];
      4'd2:    w_row5 = w_glyph[14:10];
      4'd3:    w_row5 = w_glyph[9:5];
      4'd4:    w_row5 = w_glyph[4:0];
      default: w_row5 = 5'd0;
    endcase
  end

  for (genvar j = 0; j < GLYPH_W; j++) begin : g_col
    assign bits[j] = w_row5[4 - ((GLYPH_W - 1 - j) * 5) / GLYPH_W];
  end

endmodule

// File: rtl/text_tile_renderer.sv
// Text-mode renderer: self-clearing character RAM, 3-stage beam-to-pixel
// pipeline. Optional cursor blink is enabled by TEXT_CURSOR_BLINK_EN.
module text_tile_renderer
  import text_pkg::*;
#(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int CELL_W  = DEF_CELL_W,
  parameter int CELL_H  = DEF_CELL_H,
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS
) (
  input logic clk,
  input logic reset,
  text_tile_renderer_if.slave bus
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int CW_B   = $clog2(CELL_W);
  localparam int CH_B   = $clog2(CELL_H);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clear_addr;
  logic              r_busy;
  logic [6:0]        r_mem [CELLS];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [6:0]        w_wdata;

  logic [8:0]        w_col, w_row, w_xofs, w_yofs;
  logic [ADDR_W-1:0] w_lin;
  logic              w_inr;

  logic [ADDR_W-1:0] r_s1_addr;
  logic [8:0]        r_s1_xofs, r_s1_yofs, r_s2_xofs, r_s2_yofs;
  logic              r_s1_inr, r_s1_valid, r_s2_inr, r_s2_valid;
  logic [6:0]        r_s2_char;
  logic              r_pixel, r_pixel_valid;

  logic [GLYPH_W-1:0] w_rom_bits;
  logic [7:0]         w_bits8;
  logic [2:0]         w_xidx;
  logic               w_in_glyph, w_blink, w_px;

  // Clear sequence: one space per cycle, then hand over to the write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_CLEAR;
      r_clear_addr <= '0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clear_addr <= r_clear_addr + 1'b1;
          if (r_clear_addr == ADDR_W'(CELLS - 1)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= ST_CLEAR;
          r_clear_addr <= '0;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clear_addr;
    w_wdata = CHR_SPACE;
    if (!reset) begin
      w_we = 1'b0;
    end else if (r_state == ST_CLEAR) begin
      w_we = 1'b1;
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(CELLS))) begin
      w_we    = 1'b1;
      w_waddr = bus.wr_addr;
      w_wdata = bus.wr_char;
    end else begin
      w_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_comb begin
    w_col  = bus.hpos >> CW_B;
    w_row  = bus.vpos >> CH_B;
    w_xofs = bus.hpos & 9'(CELL_W - 1);
    w_yofs = bus.vpos & 9'(CELL_H - 1);
    w_lin  = ADDR_W'(int'(w_row) * COLS + int'(w_col));
    w_inr  = (w_col < 9'(COLS)) && (w_row < 9'(ROWS));
  end

  // S1 cell decode, S2 RAM read (read-first against same-edge writes), S3 pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_addr     <= '0;
      r_s1_xofs     <= '0;
      r_s1_yofs     <= '0;
      r_s1_inr      <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s2_char     <= '0;
      r_s2_xofs     <= '0;
      r_s2_yofs     <= '0;
      r_s2_inr      <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_pixel       <= 1'b0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_s1_addr     <= w_inr ? w_lin : '0;
      r_s1_xofs     <= w_xofs;
      r_s1_yofs     <= w_yofs;
      r_s1_inr      <= w_inr;
      r_s1_valid    <= bus.display_on;
      r_s2_char     <= r_mem[r_s1_addr];
      r_s2_xofs     <= r_s1_xofs;
      r_s2_yofs     <= r_s1_yofs;
      r_s2_inr      <= r_s1_inr;
      r_s2_valid    <= r_s1_valid;
      r_pixel       <= w_px;
      r_pixel_valid <= r_s2_valid;
    end
  end

  glyph_rom #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H)
  ) u_glyph_rom (
    .code (r_s2_char),
    .yofs (r_s2_yofs[2:0]),
    .bits (w_rom_bits)
  );

`ifdef TEXT_CURSOR_BLINK_EN
  logic [4:0] r_frame_cnt;
  logic       r_vsync_d;
  logic       r_s1_cur, r_s2_cur;

  // Frame counter on vsync rising edges; cursor match travels with the pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_cnt <= 5'd0;
      r_vsync_d   <= 1'b0;
      r_s1_cur    <= 1'b0;
      r_s2_cur    <= 1'b0;
    end else begin
      r_vsync_d <= bus.vsync;
      if (bus.vsync && !r_vsync_d) r_frame_cnt <= r_frame_cnt + 5'd1;
      r_s1_cur <= w_inr && (w_lin == bus.cursor_addr);
      r_s2_cur <= r_s1_cur;
    end
  end

  assign w_blink = r_s2_cur & r_frame_cnt[4];
`else
  assign w_blink = 1'b0;
`endif

  always_comb begin
    w_in_glyph = r_s2_valid && r_s2_inr &&
                 (r_s2_xofs < 9'(GLYPH_W)) && (r_s2_yofs < 9'(GLYPH_H));
    w_bits8    = 8'(w_rom_bits);
    w_xidx     = 3'(GLYPH_W - 1) - r_s2_xofs[2:0];
    if (w_in_glyph) begin
      w_px = w_bits8[w_xidx] ^ w_blink;
    end else begin
      w_px = 1'b0;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.pixel       = r_pixel;
  assign bus.pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_text_tile_renderer.sv
// Directed bench for text_tile_renderer (default geometry): clear timing,
// glyph rendering, write-port guards, pipeline alignment, read-first collision.
module tb_text_tile_renderer;

  localparam int COLS   = 32;
  localparam int ROWS   = 30;
  localparam int ADDR_W = $clog2(COLS * ROWS);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  text_tile_renderer_if #(.ADDR_W(ADDR_W)) bus ();

  text_tile_renderer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0] h;
    logic [8:0] v;
    logic       de;
    logic       px;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int h, input int v, input logic de, input logic px);
    vecs.push_back('{9'(h), 9'(v), de, px});
  endtask

  // Streams one vector per cycle; outputs of vector k are checked 3 cycles later.
  task automatic run_vecs(input string tag);
    int n;
    n = vecs.size();
    for (int i = 0; i < n + 3; i++) begin
      if (i >= 3) begin
        check($sformatf("%s[%0d].pixel", tag, i - 3), 32'(bus.pixel), 32'(vecs[i-3].px));
        check($sformatf("%s[%0d].valid", tag, i - 3), 32'(bus.pixel_valid), 32'(vecs[i-3].de));
      end
      if (i < n) begin
        bus.hpos       = vecs[i].h;
        bus.vpos       = vecs[i].v;
        bus.display_on = vecs[i].de;
      end else begin
        bus.hpos       = 9'd0;
        bus.vpos       = 9'd0;
        bus.display_on = 1'b0;
      end
      @(negedge clk);
    end
    vecs.delete();
  endtask

  task automatic wr(input int a, input logic [6:0] c);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_char = c;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int blank_rows[5];
    logic [7:0] pat;

    bus.hpos       = 9'd0;
    bus.vpos       = 9'd0;
    bus.display_on = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_char    = 7'h00;
`ifdef TEXT_CURSOR_BLINK_EN
    bus.cursor_addr = ADDR_W'(3);
    bus.vsync       = 1'b0;
`endif

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(bus.busy), 32'd1);
    check("reset.pixel", 32'(bus.pixel), 32'd0);
    check("reset.pixel_valid", 32'(bus.pixel_valid), 32'd0);

    // Release, then interrupt the clear at cycle 500.
    reset = 1'b1;
    repeat (500) @(negedge clk);
    check("mid_clear.busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reclear_reset.busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;

    // Count busy cycles; poke the write port while busy (must be ignored).
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 2000) begin
      bus.wr_en   = (cnt == 900) || (cnt == 902);
      bus.wr_addr = (cnt == 902) ? ADDR_W'(960) : ADDR_W'(2);
      bus.wr_char = 7'h45;
      cnt++;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    check("clear_cycles", 32'(cnt), 32'd960);
    @(negedge clk);
    check("run.busy", 32'(bus.busy), 32'd0);

    // Freshly cleared buffer renders nothing.
    blank_rows = '{0, 2, 4, 100, 239};
    foreach (blank_rows[r])
      for (int h = 0; h < 256; h++) add(h, blank_rows[r], 1'b1, 1'b0);
    run_vecs("blank");

    wr(0, 7'h48);
    wr(1, 7'h41);
    wr(33, 7'h30);
    wr(959, 7'h6C);
    wr(32, 7'h48);
    wr(960, 7'h45);

    // 'H' row 2 is solid across the glyph width, blank in the gap.
    for (int h = 0; h < 8; h++) add(h, 2, 1'b1, (h < 5) ? 1'b1 : 1'b0);
    add(0, 0, 1'b1, 1'b1);
    add(1, 0, 1'b1, 1'b0);
    add(4, 0, 1'b1, 1'b1);
    add(0, 5, 1'b1, 1'b0);
    add(8, 0, 1'b1, 1'b0);
    add(9, 0, 1'b1, 1'b1);
    add(10, 0, 1'b1, 1'b1);
    add(11, 0, 1'b1, 1'b1);
    add(12, 0, 1'b1, 1'b0);
    add(8, 2, 1'b1, 1'b1);
    add(8, 9, 1'b1, 1'b1);
    add(9, 9, 1'b1, 1'b0);
    add(11, 9, 1'b1, 1'b1);
    add(12, 9, 1'b1, 1'b1);
    add(248, 236, 1'b1, 1'b0);
    add(249, 236, 1'b1, 1'b1);
    add(252, 236, 1'b1, 1'b0);
    add(249, 232, 1'b1, 1'b1);
    add(251, 232, 1'b1, 1'b0);
    add(256, 2, 1'b1, 1'b0);
    add(0, 240, 1'b1, 1'b0);
    add(0, 2, 1'b0, 1'b0);
    add(16, 0, 1'b1, 1'b0);
    run_vecs("glyph");

    // display_on pattern must come out 3 cycles later, gating the pixel.
    pat = 8'b0100_1101;
    for (int h = 0; h < 8; h++) add(h, 2, pat[h], pat[h] & ((h < 5) ? 1'b1 : 1'b0));
    run_vecs("toggle");

    // Write the cell on the same edge it is read: old (blank) data first.
    bus.hpos       = 9'd16;
    bus.vpos       = 9'd0;
    bus.display_on = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(2);
    bus.wr_char = 7'h45;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("collision.old", 32'(bus.pixel), 32'd0);
    @(negedge clk);
    check("collision.new", 32'(bus.pixel), 32'd1);
    bus.display_on = 1'b0;
    repeat (3) @(negedge clk);

`ifdef TEXT_CURSOR_BLINK_EN
    repeat (16) begin
      bus.vsync = 1'b1;
      @(negedge clk);
      bus.vsync = 1'b0;
      @(negedge clk);
    end
    for (int y = 0; y < 5; y++)
      for (int h = 24; h < 29; h++) add(h, y, 1'b1, 1'b1);
    add(29, 0, 1'b1, 1'b0);
    add(24, 5, 1'b1, 1'b0);
    run_vecs("cursor_on");
    repeat (16) begin
      bus.vsync = 1'b1;
      @(negedge clk);
      bus.vsync = 1'b0;
      @(negedge clk);
    end
    for (int y = 0; y < 5; y++)
      for (int h = 24; h < 29; h++) add(h, y, 1'b1, 1'b0);
    run_vecs("cursor_off");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
